sqrt_lane_pool: RTL

Parametrised pool of iterative square-root lanes with round-robin dispatch and in-order return. It replaces the fixed five-unit sqrt bank, one-hot result mux and side FIFOs between the discriminant stage and the second intersection stage. Each radicand travels with a sideband payload, such as ray direction, 1/2A or B, so results and payload leave together and in issue order. Valid/ready handshakes on both sides give backpressure instead of dropping results.

---
 rtl/sqrt_lane_pool.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sqrt_lane_pool.sv
// -----------------------------------------------------------------------------
// sqrt_lane_pool
//
// Pool of LANES identical iterative square-root lanes. Radicands are issued
// round-robin to the lanes and results are drained with the same rotation.
// Every lane has the same latency, so results leave in issue order together
// with the sideband payload that came in with their radicand.
//
// Optional build macro: SQRT_POOL_NEG_CLAMP_EN
//   defined   : in_radicand is two's complement. A negative radicand still
//               occupies a lane for the full latency and returns out_root=0,
//               out_neg=1.
//   undefined : in_radicand is unsigned and out_neg is tied to 0.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   in_valid      radicand/sideband valid
//   in_ready      pool accepts this cycle (registered state only)
//   in_radicand   DATA_W radicand (Q36.28 at default width)
//   in_side       SIDE_W sideband payload
//   out_valid     result valid
//   out_ready     downstream accepts
//   out_root      DATA_W/2 floor(sqrt(radicand)) (Q18.14 at default width)
//   out_side      sideband payload of the same transaction
//   out_neg       radicand was negative (clamp build only)
//   lanes_busy    per-lane non-IDLE flag, debug view of the lane FSMs
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its data stable until that edge; ready
// never depends combinationally on the valid of the same interface.
// -----------------------------------------------------------------------------
module sqrt_lane_pool #(
   parameter int DATA_W = 64,
   parameter int LANES  = 5,
   parameter int SIDE_W = 96
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_radicand,
   input  logic [SIDE_W-1:0]   in_side,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W/2-1:0] out_root,
   output logic [SIDE_W-1:0]   out_side,
   output logic                out_neg,
   output logic [LANES-1:0]    lanes_busy
);

   localparam int HALF_W  = DATA_W / 2;
   localparam int REM_W   = HALF_W + 2;
   localparam int TRIAL_W = REM_W + 2;
   localparam int CNT_W   = $clog2(HALF_W + 1);
   localparam int PTR_W   = (LANES > 1) ? $clog2(LANES) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } lane_st_e;

   lane_st_e            st_q   [LANES];
   lane_st_e            st_d   [LANES];
   logic [DATA_W-1:0]   rad_q  [LANES];
   logic [DATA_W-1:0]   rad_d  [LANES];
   logic [REM_W-1:0]    rem_q  [LANES];
   logic [REM_W-1:0]    rem_d  [LANES];
   logic [HALF_W-1:0]   root_q [LANES];
   logic [HALF_W-1:0]   root_d [LANES];
   logic [CNT_W-1:0]    cnt_q  [LANES];
   logic [CNT_W-1:0]    cnt_d  [LANES];
   logic [SIDE_W-1:0]   side_q [LANES];
   logic [SIDE_W-1:0]   side_d [LANES];
   logic                neg_q  [LANES];
   logic                neg_d  [LANES];
   logic [TRIAL_W-1:0]  trial  [LANES];

   logic [PTR_W-1:0]    issue_ptr_q, issue_ptr_d;
   logic [PTR_W-1:0]    ret_ptr_q, ret_ptr_d;
   logic                accept;
   logic                retire;
   logic                in_neg;

`ifdef SQRT_POOL_NEG_CLAMP_EN
   assign in_neg  = in_radicand[DATA_W-1];
   assign out_neg = out_valid & neg_q[ret_ptr_q];
`else
   assign in_neg  = 1'b0;
   assign out_neg = 1'b0;
`endif

   assign in_ready  = (st_q[issue_ptr_q] == ST_IDLE);
   assign out_valid = (st_q[ret_ptr_q] == ST_DONE);
   assign accept    = in_valid & in_ready;
   assign retire    = out_valid & out_ready;

   // Outputs are forced to 0 when nothing is presented so an idle lane's
   // leftover result never shows on the bus.
   assign out_root = (out_valid && !neg_q[ret_ptr_q]) ? root_q[ret_ptr_q] : '0;
   assign out_side = out_valid ? side_q[ret_ptr_q] : '0;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         lanes_busy[i] = (st_q[i] != ST_IDLE);
      end
   end

   always_comb begin
      issue_ptr_d = issue_ptr_q;
      ret_ptr_d   = ret_ptr_q;
      if (accept) begin
         issue_ptr_d = (issue_ptr_q == PTR_W'(LANES - 1)) ? '0 : issue_ptr_q + 1'b1;
      end
      if (retire) begin
         ret_ptr_d = (ret_ptr_q == PTR_W'(LANES - 1)) ? '0 : ret_ptr_q + 1'b1;
      end

      for (int i = 0; i < LANES; i++) begin
         st_d[i]   = st_q[i];
         rad_d[i]  = rad_q[i];
         rem_d[i]  = rem_q[i];
         root_d[i] = root_q[i];
         cnt_d[i]  = cnt_q[i];
         side_d[i] = side_q[i];
         neg_d[i]  = neg_q[i];

         // Restoring step: bring down the next two radicand bits and try to
         // subtract 4*root+1. The top two bits of the difference are 00 for a
         // non-negative result and 11 for a negative one.
         trial[i] = {rem_q[i], rad_q[i][DATA_W-1 -: 2]} - TRIAL_W'({root_q[i], 2'b01});

         case (st_q[i])
            ST_IDLE: begin
               if (accept && (issue_ptr_q == PTR_W'(i))) begin
                  st_d[i]   = ST_RUN;
                  rad_d[i]  = in_radicand;
                  side_d[i] = in_side;
                  neg_d[i]  = in_neg;
                  rem_d[i]  = '0;
                  root_d[i] = '0;
                  cnt_d[i]  = CNT_W'(HALF_W);
               end
            end
            ST_RUN: begin
               rad_d[i] = {rad_q[i][DATA_W-3:0], 2'b00};
               if (trial[i][TRIAL_W-1 -: 2] == 2'b00) begin
                  rem_d[i]  = trial[i][REM_W-1:0];
                  root_d[i] = {root_q[i][HALF_W-2:0], 1'b1};
               end else begin
                  // The partial remainder stays below 2^HALF_W, so its low
                  // HALF_W bits carry the whole value.
                  rem_d[i]  = {rem_q[i][REM_W-3:0], rad_q[i][DATA_W-1 -: 2]};
                  root_d[i] = {root_q[i][HALF_W-2:0], 1'b0};
               end
               cnt_d[i] = cnt_q[i] - 1'b1;
               if (cnt_q[i] == CNT_W'(1)) begin
                  st_d[i] = ST_DONE;
               end
            end
            ST_DONE: begin
               if (retire && (ret_ptr_q == PTR_W'(i))) begin
                  st_d[i] = ST_IDLE;
               end
            end
            default: begin
               st_d[i] = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_ptr_q <= '0;
         ret_ptr_q   <= '0;
         for (int i = 0; i < LANES; i++) begin
            st_q[i]   <= ST_IDLE;
            rad_q[i]  <= '0;
            rem_q[i]  <= '0;
            root_q[i] <= '0;
            cnt_q[i]  <= '0;
            side_q[i] <= '0;
            neg_q[i]  <= 1'b0;
         end
      end else begin
         issue_ptr_q <= issue_ptr_d;
         ret_ptr_q   <= ret_ptr_d;
         for (int i = 0; i < LANES; i++) begin
            st_q[i]   <= st_d[i];
            rad_q[i]  <= rad_d[i];
            rem_q[i]  <= rem_d[i];
            root_q[i] <= root_d[i];
            cnt_q[i]  <= cnt_d[i];
            side_q[i] <= side_d[i];
            neg_q[i]  <= neg_d[i];
         end
      end
   end

endmodule
